// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// The compare digit is two bits wide; operands are scanned one digit per clock.
package cmp_pkg;

  localparam int DIGIT_W = 2;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot compare outcome; all-zero means "no result yet".
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } result_t;

  // Width of a down-counter that must hold values 0..d-1, never narrower than one bit.
  function automatic int idx_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/serial_cmp_ctrl_if.sv
// Start/ready handshake, operands and registered results of the serial comparator.
// The requester drives start/a/b; the comparator drives ready/done and the result flags.
interface serial_cmp_ctrl_if #(
  parameter int W = 8
);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic         agtb;
  logic         aeqb;
  logic         altb;

  modport master (
    output start,
    output a,
    output b,
    input  ready,
    input  done,
    input  agtb,
    input  aeqb,
    input  altb
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output ready,
    output done,
    output agtb,
    output aeqb,
    output altb
  );

endinterface

// File: rtl/cmp2_cell.sv
// Combinational 2-bit unsigned greater-than cell.
// The controller instantiates it twice with swapped operands to obtain both gt and lt.
module cmp2_cell
  import cmp_pkg::*;
(
  input  digit_t x,
  input  digit_t y,
  output logic   gt
);

  // x > y for 2-bit unsigned: MSB decides, otherwise LSB decides on equal MSBs.
  assign gt = (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Sequenced MSB-first magnitude comparator: one 2-bit digit per clock through a shared cell,
// stopping at the first differing digit and reporting the result with a one-cycle done pulse.
module serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  serial_cmp_ctrl_if.slave     bus
);

  localparam int D     = W / DIGIT_W;
  localparam int IDX_W = idx_width(D);

  if ((W % DIGIT_W) != 0 || W < DIGIT_W) begin : g_bad_width
    $error("serial_cmp_ctrl: W must be even and at least 2");
  end

  state_t           state;
  state_t           state_nxt;
  logic [W-1:0]     sh_a;
  logic [W-1:0]     sh_b;
  logic [IDX_W-1:0] idx;
  result_t          result_q;

  digit_t           dig_a;
  digit_t           dig_b;
  logic             gt;
  logic             lt;

  logic             load;
  logic             shift;
  logic             set_gt;
  logic             set_lt;
  logic             set_eq;

  assign dig_a = sh_a[W-1 -: DIGIT_W];
  assign dig_b = sh_b[W-1 -: DIGIT_W];

  cmp2_cell u_cmp_gt (
    .x  (dig_a),
    .y  (dig_b),
    .gt (gt)
  );

  cmp2_cell u_cmp_lt (
    .x  (dig_b),
    .y  (dig_a),
    .gt (lt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    set_gt    = 1'b0;
    set_lt    = 1'b0;
    set_eq    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SCAN;
        end
      end

      SCAN: begin
        if (gt) begin
          set_gt    = 1'b1;
          state_nxt = DONE;
        end else if (lt) begin
          set_lt    = 1'b1;
          state_nxt = DONE;
        end else if (idx == '0) begin
          set_eq    = 1'b1;
          state_nxt = DONE;
        end else begin
          shift     = 1'b1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand shift registers and digit index: loaded on acceptance, advanced while scanning.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_a <= '0;
      sh_b <= '0;
      idx  <= '0;
    end else if (load) begin
      sh_a <= bus.a;
      sh_b <= bus.b;
      idx  <= IDX_W'(D - 1);
    end else if (shift) begin
      sh_a <= sh_a << DIGIT_W;
      sh_b <= sh_b << DIGIT_W;
      idx  <= idx - IDX_W'(1);
    end
  end

  // Results are cleared on acceptance and hold after the decision until the next acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
    end else if (load) begin
      result_q <= '0;
    end else begin
      if (set_gt) result_q.gt <= 1'b1;
      if (set_lt) result_q.lt <= 1'b1;
      if (set_eq) result_q.eq <= 1'b1;
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = (state == DONE);
  assign bus.agtb  = result_q.gt;
  assign bus.aeqb  = result_q.eq;
  assign bus.altb  = result_q.lt;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench for serial_cmp_ctrl (W=8): latency, result flags, handshake and reset abort.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_cmp_ctrl;

  logic clk;
  logic reset_n;

  int tests;
  int fails;

  serial_cmp_ctrl_if #(.W(8)) bus ();

  serial_cmp_ctrl #(.W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Starts a compare from a falling edge and checks latency k, the done pulse and the flags.
  task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input int exp_k, input logic eg, input logic ee, input logic el);
    int wait_n;
    int lat;
    wait_n = 0;
    while (!bus.ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, "_ready_before"}, 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = av;
    check({tag, "_ready_in_scan"}, 32'(bus.ready), 32'd0);
    if (exp_k > 1) begin
      check({tag, "_cleared"}, {29'd0, bus.agtb, bus.aeqb, bus.altb}, 32'd0);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 12);
    check({tag, "_latency"}, 32'(lat), 32'(exp_k));
    check({tag, "_flags"}, {29'd0, bus.agtb, bus.aeqb, bus.altb}, {29'd0, eg, ee, el});
    check({tag, "_ready_in_done"}, 32'(bus.ready), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int accepts;
    int dones;
    int stray;
    tests     = 0;
    fails     = 0;
    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h00;

    // Reset held with start asserted.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_flags", {29'd0, bus.agtb, bus.aeqb, bus.altb}, 32'd0);
    bus.start = 1'b0;
    reset_n   = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(bus.ready), 32'd1);
    check("idle_done",  32'(bus.done),  32'd0);
    check("idle_flags", {29'd0, bus.agtb, bus.aeqb, bus.altb}, 32'd0);

    // Digits MSB-first: C3 = 11_00_00_11, 83 = 10_00_00_11 -> differ at digit 1.
    run_cmp("c3_83", 8'hC3, 8'h83, 1, 1'b1, 1'b0, 1'b0);
    // 30 = 00_11_00_00, 20 = 00_10_00_00 -> differ at digit 2.
    run_cmp("30_20", 8'h30, 8'h20, 2, 1'b1, 1'b0, 1'b0);
    // 04 = 00_00_01_00, 08 = 00_00_10_00 -> differ at digit 3.
    run_cmp("04_08", 8'h04, 8'h08, 3, 1'b0, 1'b0, 1'b1);
    // 12 = 00_01_00_10, 13 = 00_01_00_11 -> differ at digit 4.
    run_cmp("12_13", 8'h12, 8'h13, 4, 1'b0, 1'b0, 1'b1);
    // Equal operands scan all four digits.
    run_cmp("5a_5a", 8'h5A, 8'h5A, 4, 1'b0, 1'b1, 1'b0);

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("eq_hold_flags", {29'd0, bus.agtb, bus.aeqb, bus.altb}, 32'b010);
      check("eq_hold_done", 32'(bus.done), 32'd0);
    end

    // start held high: each acceptance costs k+2 = 3 cycles, so 30 cycles give 10.
    accepts   = 0;
    dones     = 0;
    bus.start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (bus.ready) begin
        bus.a = (accepts % 2 == 0) ? 8'hFF : 8'h00;
        bus.b = (accepts % 2 == 0) ? 8'h00 : 8'hFF;
        accepts++;
      end else begin
        bus.a = 8'h55;
        bus.b = 8'h55;
      end
      @(negedge clk);
      if (bus.done) begin
        check("burst_flags", {29'd0, bus.agtb, bus.aeqb, bus.altb},
              (dones % 2 == 0) ? 32'b100 : 32'b001);
        dones++;
      end
    end
    bus.start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("burst_accepts", 32'(accepts), 32'd10);
    check("burst_dones",   32'(dones),   32'd10);

    // Reset during the second SCAN cycle of 01 vs 02 aborts without a done pulse.
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_in_scan", 32'(bus.ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_done",  32'(bus.done),  32'd0);
    check("abort_flags", {29'd0, bus.agtb, bus.aeqb, bus.altb}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    stray   = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done) stray++;
    end
    check("abort_no_done", 32'(stray), 32'd0);

    // 40 = 01_00_00_00 on both sides -> full scan, equal.
    run_cmp("40_40", 8'h40, 8'h40, 4, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_cmp_ctrl.md
# serial_cmp_ctrl

Sequenced magnitude comparator for W-bit unsigned operands. The operand pair is latched on a start/ready handshake and scanned MSB-first, one 2-bit digit per clock, through a single shared 2-bit compare cell. Scanning stops at the first differing digit. The result is registered and reported with a one-cycle `done` pulse. The block is the controller that lets the 2-bit greater-than datapath serve arbitrary operand widths.

## Interface
- `W`, default 8: operand width. Must be even and ≥ 2. Digit count D = W/2.
- `clk`, input, 1: system clock, rising-edge.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request a compare. Accepted only on an edge where `ready`=1.
- `a`, input, W: operand A, sampled on the accepting edge.
- `b`, input, W: operand B, sampled on the accepting edge.
- `ready`, output, 1: block is idle and will accept `start`.
- `done`, output, 1: single-cycle pulse; the result is valid in that cycle.
- `agtb`, output, 1: A > B.
- `aeqb`, output, 1: A == B.
- `altb`, output, 1: A < B.

## Operation
- FSM states: IDLE, SCAN, DONE.
- Reset state is IDLE. Reset values: `ready`=1, `done`=0, `agtb`=`aeqb`=`altb`=0, digit index=0, shift registers=0.
- **IDLE**: `ready`=1. When `start`=1 at an edge:
  - load `a` and `b` into shift registers;
  - set digit index to D-1;
  - clear all three result bits;
  - go to SCAN.
- **SCAN**: `ready`=0. The top digit of each shift register drives the compare cell twice, as (a,b) and as (b,a), giving `gt` and `lt`. At each edge:
  - `gt` → `agtb`=1, go to DONE;
  - else `lt` → `altb`=1, go to DONE;
  - else index==0 → `aeqb`=1, go to DONE;
  - else shift both registers left by 2 and decrement the index.
- **DONE**: `done`=1 and `ready`=0 for exactly one cycle, then unconditional return to IDLE.
- Result bits are one-hot once set. They hold until the next accepted `start` clears them.
- `start` is ignored in SCAN and DONE. It is not queued.
- `a` and `b` are don't-care except on the accepting edge.
- Reset asserted mid-SCAN or mid-DONE: the FSM returns to IDLE immediately, no `done` is emitted, and the results are cleared.

## Timing
- Acceptance edge E0. Let k be the 1-based position of the first differing digit from the MSB, with k = D if the operands are equal.
- The decision is made at edge E_k. `done` and the results are valid in the cycle after E_k. `ready` rises after E_{k+1}.
- Latency from the accepting edge to `done` is k cycles: min 1, max D (4 for W=8).
- The earliest next acceptance is at edge E_{k+2}, so the repeat interval is k+2 cycles.
- All outputs are registered, or decoded from the state register only. No combinational path from inputs to outputs.

## Structure
- Package `cmp_pkg`:
  - `state_t` enum {IDLE, SCAN, DONE};
  - `digit_t` (logic [1:0]);
  - constant `DIGIT_W` = 2.
- Sub-module `cmp2_cell`: combinational 2-bit compare, output `gt`=(x>y). It is instantiated twice, once with operands swapped, to produce `gt` and `lt`.
- The digit index counter is $clog2(D) bits wide, with a minimum of 1.
- The top level holds the FSM, the shift registers, the counter and the result registers.

## Test plan
- Reset: hold `reset_n`=0 with `start`=1 → `ready`=1, `done`=0, all results 0. After release, outputs hold until `start` is accepted.
- W=8, a=0xC3, b=0x83 → MSB digits differ (11 vs 10); `done` one cycle after acceptance; `agtb`=1, `aeqb`=`altb`=0.
- W=8, a=0x12, b=0x13 → last digit differs; `done` 4 cycles after acceptance; `altb`=1.
- W=8, a=b=0x5A → `done` after 4 cycles; `aeqb`=1. Results hold for 10 idle cycles.
- `start` pulsed every cycle, with a=0xFF,b=0x00 then a=0x00,b=0xFF → exactly one acceptance per ready window; results alternate `agtb`, `altb`; `done` count equals the acceptance count.
- Assert `reset_n` at the 2nd SCAN cycle of a=0x01,b=0x02 → immediate IDLE with no `done`. A following compare of 0x40 vs 0x40 completes with `aeqb`=1.
